// File: rtl/musa_chk_pkg.sv
// Shared types and helpers for the MUSA control-signal temporal checker.
package musa_chk_pkg;

    localparam int CFG_W = 8;

    typedef struct packed {
        logic [CFG_W-1:0] win_min;
        logic [CFG_W-1:0] win_max;
    } chk_cfg_t;

    function automatic logic win_legal(input int unsigned mn, input int unsigned mx,
                                       input int unsigned max_win);
        return (mn >= 1) && (mn <= mx) && (mx <= max_win);
    endfunction

    // Saturates at the all-ones value of a w-bit counter (w up to 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/musa_chk_channel.sv
// One checker channel: overlapping-attempt tracker plus optional pass counter
// (pass counter built only when CHK_COVER_EN is defined).
module musa_chk_channel
    import musa_chk_pkg::*;
#(
    parameter int MAX_WIN = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             flush,
    input  logic             create,
    input  logic             trig,
    input  logic             resp,
    input  logic [CFG_W-1:0] win_min,
    input  logic [CFG_W-1:0] win_max,
    output logic             fail_now,
    output logic             pending,
    output logic [CNT_W-1:0] pass_count
);

    // Bit a set: an attempt will be of age a at the coming edge.
    logic [MAX_WIN:1] pend;
    logic [MAX_WIN:1] pend_next;

`ifdef CHK_COVER_EN
    localparam int DW = $clog2(MAX_WIN + 1);
    logic [DW-1:0] dis_cnt;
`endif

    always_comb begin
        pend_next = '0;
        fail_now  = 1'b0;
`ifdef CHK_COVER_EN
        dis_cnt   = '0;
`endif
        for (int a = 1; a <= MAX_WIN; a++) begin
            if (pend[a]) begin
                if (resp && a >= int'(win_min)) begin
`ifdef CHK_COVER_EN
                    dis_cnt = dis_cnt + DW'(1);
`endif
                end else if (a >= int'(win_max)) begin
                    fail_now = 1'b1;
                end else if (a < MAX_WIN) begin
                    pend_next[a+1] = 1'b1;
                end
            end
        end
        if (flush) begin
            pend_next = '0;
            fail_now  = 1'b0;
`ifdef CHK_COVER_EN
            dis_cnt   = '0;
`endif
        end
        // The new attempt starts at age 0, so a same-edge resp never touches it.
        if (create && trig) begin
            pend_next[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    assign pending = |pend;

`ifdef CHK_COVER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count <= '0;
        end else if (clear) begin
            pass_count <= '0;
        end else begin
            pass_count <= CNT_W'(sat_add(32'(pass_count), 32'(dis_cnt), CNT_W));
        end
    end
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign pass_count   = '0;
`endif

endmodule

// File: rtl/musa_ctrl_checker.sv
// Trigger-implies-response-within-window checker for MUSA control signals.
// Optional per-channel pass counters are enabled by defining CHK_COVER_EN.
module musa_ctrl_checker
    import musa_chk_pkg::*;
#(
    parameter int NUM_CHK = 12,
    parameter int MAX_WIN = 8,
    parameter int CNT_W   = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          en,
    input  logic [NUM_CHK-1:0]                            trig,
    input  logic [NUM_CHK-1:0]                            resp,
    input  logic                                          cfg_load,
    input  logic [$clog2(MAX_WIN+1)-1:0]                  win_min,
    input  logic [$clog2(MAX_WIN+1)-1:0]                  win_max,
    input  logic                                          clear,
    output logic                                          cfg_err,
    output logic                                          busy,
    output logic [NUM_CHK-1:0]                            fail_pulse,
    output logic [NUM_CHK-1:0]                            fail_sticky,
    output logic [CNT_W-1:0]                              fail_count,
    output logic                                          first_fail_valid,
    output logic [(NUM_CHK>1 ? $clog2(NUM_CHK) : 1)-1:0]  first_fail_id,
    output logic [NUM_CHK*CNT_W-1:0]                      pass_count
);

    localparam int ID_W = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;

    chk_cfg_t            cfg;
    logic                load_err;
    logic                err_next;
    logic                create;
    logic [NUM_CHK-1:0]  fail_now;
    logic [NUM_CHK-1:0]  pend_any;
    logic [31:0]         fail_pop;
    logic [ID_W-1:0]     fail_low;

    // A trig on the cfg_load edge is judged against the window being loaded.
    assign load_err = !win_legal(32'(win_min), 32'(win_max), MAX_WIN);
    assign err_next = cfg_load ? load_err : cfg_err;
    assign create   = en && !err_next;
    assign busy     = |pend_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg.win_min <= CFG_W'(1);
            cfg.win_max <= CFG_W'(MAX_WIN);
            cfg_err     <= 1'b0;
        end else if (cfg_load) begin
            cfg.win_min <= CFG_W'(win_min);
            cfg.win_max <= CFG_W'(win_max);
            cfg_err     <= load_err;
        end
    end

    for (genvar g = 0; g < NUM_CHK; g++) begin : g_chan
        musa_chk_channel #(
            .MAX_WIN (MAX_WIN),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .flush      (cfg_load),
            .create     (create),
            .trig       (trig[g]),
            .resp       (resp[g]),
            .win_min    (cfg.win_min),
            .win_max    (cfg.win_max),
            .fail_now   (fail_now[g]),
            .pending    (pend_any[g]),
            .pass_count (pass_count[g*CNT_W +: CNT_W])
        );
    end

    // Descending scan leaves the lowest failing index in fail_low.
    always_comb begin
        fail_pop = '0;
        fail_low = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (fail_now[i]) begin
                fail_pop = fail_pop + 32'd1;
                fail_low = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_pulse       <= '0;
            fail_sticky      <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_id    <= '0;
        end else begin
            fail_pulse <= fail_now;
            if (clear) begin
                fail_sticky      <= '0;
                fail_count       <= '0;
                first_fail_valid <= 1'b0;
                first_fail_id    <= '0;
            end else begin
                fail_sticky <= fail_sticky | fail_now;
                fail_count  <= CNT_W'(sat_add(32'(fail_count), fail_pop, CNT_W));
                if (!first_fail_valid && (|fail_now)) begin
                    first_fail_valid <= 1'b1;
                    first_fail_id    <= fail_low;
                end
            end
        end
    end

endmodule
